// File: rtl/binary_calculator.sv
// binary_calculator: command-driven ALU that packs {InA, InB, Sel, Flags, Result}
// into one packet and streams it MSB-chunk first on a divided transmit clock.
// Optional packet memory is built only when BINCALC_MEM_EN is defined; without it
// InputKey, RW and Addr are ignored and every command is a compute command.
module binary_calculator #(
    parameter int INBITS = 8,
    parameter int WIDTH  = 8,
    parameter int SBITS  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InputKey,
    input  logic              ValidCmd,
    input  logic [INBITS-1:0] InA,
    input  logic [INBITS-1:0] InB,
    input  logic              RW,
    input  logic [WIDTH-1:0]  Addr,
    input  logic [3:0]        Sel,
    input  logic [31:0]       Din,
    input  logic              ConfigDiv,
    output logic              CalcBusy,
    output logic              ClkTx,
    output logic              DoutValid,
    output logic [SBITS-1:0]  DataOut
);

    localparam int P    = 8 + 3 * INBITS;           // packet width
    localparam int N    = (P + SBITS - 1) / SBITS;  // chunks per packet
    localparam int TW   = N * SBITS;                // padded transmit width
    localparam int PADW = TW - P;                   // zero padding at LSB end
    localparam int CW   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, TX} state_t;

    state_t            state_reg;
    logic              valid_prev_reg;
    logic [INBITS-1:0] a_reg;
    logic [INBITS-1:0] b_reg;
    logic [3:0]        sel_reg;
    logic [7:0]        div_reg;
    logic [7:0]        cnt_reg;
    logic [CW-1:0]     chunk_reg;
    logic [TW-1:0]     shift_reg;
    logic              busy_reg;
    logic              clktx_reg;
    logic              dvalid_reg;

    logic              accept_w;
    logic              mem_write_w;
    logic [INBITS-1:0] result_w;
    logic              carry_w;
    logic              invalid_w;
    logic [INBITS:0]   sum_w;
    logic [INBITS:0]   diff_w;
    logic [2*INBITS-1:0] prod_w;
    logic [3:0]        flags_w;
    logic [P-1:0]      packet_w;
    logic [P-1:0]      tx_src_w;
    logic [TW-1:0]     tx_word_w;

    // A command starts only on a fresh ValidCmd rising edge seen while idle
    assign accept_w = (state_reg == IDLE) && ValidCmd && !valid_prev_reg;

    // ALU on the latched operands; flags derived from the selected result
    always_comb begin
        result_w  = '0;
        carry_w   = 1'b0;
        invalid_w = 1'b0;
        sum_w     = {1'b0, a_reg} + {1'b0, b_reg};
        diff_w    = {1'b0, a_reg} - {1'b0, b_reg};
        prod_w    = {{INBITS{1'b0}}, a_reg} * {{INBITS{1'b0}}, b_reg};
        case (sel_reg)
            4'd0: begin
                result_w = sum_w[INBITS-1:0];
                carry_w  = sum_w[INBITS];
            end
            4'd1: begin
                result_w = diff_w[INBITS-1:0];
                carry_w  = diff_w[INBITS];
            end
            4'd2: begin
                result_w = prod_w[INBITS-1:0];
                carry_w  = |prod_w[2*INBITS-1:INBITS];
            end
            4'd3:    result_w = a_reg & b_reg;
            4'd4:    result_w = a_reg | b_reg;
            4'd5:    result_w = a_reg ^ b_reg;
            4'd6:    result_w = ~a_reg;
            4'd7:    result_w = a_reg << b_reg[2:0];
            4'd8:    result_w = a_reg >> b_reg[2:0];
            default: invalid_w = 1'b1;
        endcase
        flags_w  = {(result_w == '0), carry_w, invalid_w, 1'b0};
        packet_w = {a_reg, b_reg, sel_reg, flags_w, result_w};
    end

`ifdef BINCALC_MEM_EN
    localparam int DEPTH = 1 << WIDTH;

    logic [P-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]   entry_valid_reg;
    logic               key_reg;
    logic               rw_reg;
    logic [WIDTH-1:0]   addr_reg;
    logic [P-1:0]       rd_data_reg;
    logic               rd_valid_reg;

    assign mem_write_w = key_reg && rw_reg;
    // A read of a never-written entry sends an all-zero packet
    assign tx_src_w    = key_reg ? (rd_valid_reg ? rd_data_reg : '0) : packet_w;

    // Packet RAM: write during LOAD of a write command, registered read at accept
    always_ff @(posedge Clk) begin
        if (state_reg == LOAD && mem_write_w) begin
            mem[addr_reg] <= packet_w;
        end
        if (accept_w) begin
            rd_data_reg <= mem[Addr];
        end
    end

    // Mode latches and per-entry valid bits, cleared by reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            entry_valid_reg <= '0;
            key_reg         <= 1'b0;
            rw_reg          <= 1'b0;
            addr_reg        <= '0;
            rd_valid_reg    <= 1'b0;
        end else begin
            if (accept_w) begin
                key_reg      <= InputKey;
                rw_reg       <= RW;
                addr_reg     <= Addr;
                rd_valid_reg <= entry_valid_reg[Addr];
            end
            if (state_reg == LOAD && mem_write_w) begin
                entry_valid_reg[addr_reg] <= 1'b1;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^Din[31:8];
`else
    assign mem_write_w = 1'b0;
    assign tx_src_w    = packet_w;

    logic unused_inputs;
    assign unused_inputs = ^{InputKey, RW, Addr, Din[31:8]};
`endif

    // Left-align the packet so padding lands at the LSB end of the last chunk
    assign tx_word_w = TW'(tx_src_w) << PADW;

    // Command FSM, divider register and transmit shifter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            valid_prev_reg <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            sel_reg        <= '0;
            div_reg        <= 8'd1;
            cnt_reg        <= '0;
            chunk_reg      <= '0;
            shift_reg      <= '0;
            busy_reg       <= 1'b0;
            clktx_reg      <= 1'b0;
            dvalid_reg     <= 1'b0;
        end else begin
            valid_prev_reg <= ValidCmd;
            case (state_reg)
                IDLE: begin
                    if (ConfigDiv) begin
                        div_reg <= (Din[7:0] == 8'd0) ? 8'd1 : Din[7:0];
                    end
                    if (accept_w) begin
                        a_reg     <= InA;
                        b_reg     <= InB;
                        sel_reg   <= Sel;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (mem_write_w) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        shift_reg  <= tx_word_w;
                        dvalid_reg <= 1'b1;
                        clktx_reg  <= 1'b0;
                        cnt_reg    <= '0;
                        chunk_reg  <= '0;
                        state_reg  <= TX;
                    end
                end
                TX: begin
                    if (cnt_reg == div_reg - 8'd1) begin
                        cnt_reg <= '0;
                        if (clktx_reg) begin
                            clktx_reg <= 1'b0;
                            if (chunk_reg == CW'(N - 1)) begin
                                shift_reg  <= '0;
                                dvalid_reg <= 1'b0;
                                busy_reg   <= 1'b0;
                                state_reg  <= IDLE;
                            end else begin
                                shift_reg <= shift_reg << SBITS;
                                chunk_reg <= chunk_reg + CW'(1);
                            end
                        end else begin
                            clktx_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign CalcBusy  = busy_reg;
    assign ClkTx     = clktx_reg;
    assign DoutValid = dvalid_reg;
    assign DataOut   = shift_reg[TW-1 -: SBITS];

endmodule

// File: tb/tb_binary_calculator.sv
// Testbench for binary_calculator: directed test-plan steps followed by random
// commands, each checked cycle by cycle against a plain-arithmetic reference model.
module tb_binary_calculator;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InputKey, ValidCmd, RW, ConfigDiv;
    logic [7:0]  InA, InB, Addr;
    logic [3:0]  Sel;
    logic [31:0] Din;
    logic        CalcBusy, ClkTx, DoutValid;
    logic [3:0]  DataOut;

    int tests = 0;
    int fails = 0;
    int div_model = 1;
    logic [31:0] mem_m [256];
    bit          vld_m [256];

    binary_calculator dut (
        .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd),
        .InA(InA), .InB(InB), .RW(RW), .Addr(Addr), .Sel(Sel), .Din(Din),
        .ConfigDiv(ConfigDiv), .CalcBusy(CalcBusy), .ClkTx(ClkTx),
        .DoutValid(DoutValid), .DataOut(DataOut)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packet from the arithmetic rules: {A, B, Sel, Flags, Result}
    function automatic logic [31:0] ref_packet(input int a, input int b, input int sel);
        int res, full;
        int c, inv;
        res = 0; c = 0; inv = 0;
        case (sel)
            0: begin full = a + b; res = full % 256; c = (full > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: begin full = a * b; res = full % 256; c = (full > 255) ? 1 : 0; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - a;
            7: res = (a * (1 << (b % 8))) % 256;
            8: res = a / (1 << (b % 8));
            default: inv = 1;
        endcase
        return (a << 24) | (b << 16) | (sel << 12) |
               (((res == 0) ? 8 : 0) + c * 4 + inv * 2) << 8 | res;
    endfunction

    task automatic model_reset();
        div_model = 1;
        for (int i = 0; i < 256; i++) vld_m[i] = 0;
    endtask

    task automatic config_div(input int d);
        @(negedge Clk);
        ConfigDiv = 1'b1;
        Din = ($urandom() & 32'hFFFF_FF00) | 32'(d);
        @(negedge Clk);
        ConfigDiv = 1'b0;
        div_model = (d == 0) ? 1 : d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(CalcBusy), 32'd0);
        chk({tag, "_clktx"}, 32'(ClkTx), 32'd0);
        chk({tag, "_dvalid"}, 32'(DoutValid), 32'd0);
        chk({tag, "_dout"}, 32'(DataOut), 32'd0);
    endtask

    // Issue one command and check the whole response; disturb pokes ValidCmd and
    // ConfigDiv mid-transmit, rst_at (>=0) asserts reset at that TX cycle.
    task automatic run_cmd(input string tag, input bit key, input bit rw, input int addr,
                           input int a, input int b, input int sel,
                           input bit disturb, input int rst_at);
        logic [31:0] pkt;
        bit tx;
        int div, i, ph;
        div = div_model;
        tx  = 1;
        pkt = ref_packet(a, b, sel);
`ifdef BINCALC_MEM_EN
        if (key && rw) begin
            mem_m[addr] = pkt;
            vld_m[addr] = 1;
            tx = 0;
        end else if (key) begin
            pkt = vld_m[addr] ? mem_m[addr] : 32'd0;
        end
`endif
        $display("[TB] %s key=%0d rw=%0d addr=%0d a=%0d b=%0d sel=%0d div=%0d tx=%0d pkt=%08h",
                 tag, key, rw, addr, a, b, sel, div, tx, pkt);
        @(negedge Clk);
        InputKey = key; RW = rw; Addr = 8'(addr);
        InA = 8'(a); InB = 8'(b); Sel = 4'(sel);
        ValidCmd = 1'b1;
        @(posedge Clk); #1;
        ValidCmd = 1'b0;
        chk({tag, "_acc_busy"}, 32'(CalcBusy), 32'd1);
        chk({tag, "_acc_dvalid"}, 32'(DoutValid), 32'd0);
        @(posedge Clk); #1;
        if (!tx) begin
            chk({tag, "_wr_busy"}, 32'(CalcBusy), 32'd0);
            repeat (3) begin
                chk({tag, "_wr_dvalid"}, 32'(DoutValid), 32'd0);
                @(posedge Clk); #1;
            end
            return;
        end
        for (int t = 0; t < 16 * div; t++) begin
            i  = t / (2 * div);
            ph = t % (2 * div);
            if (t == rst_at) begin
                Reset = 1'b0;
                #1;
                chk_idle({tag, "_rst"});
                model_reset();
                @(negedge Clk);
                Reset = 1'b1;
                return;
            end
            if (disturb && t == 4 * div) begin
                ValidCmd = 1'b1; ConfigDiv = 1'b1; Din = 32'd7;
            end
            if (disturb && t == 4 * div + 1) begin
                ValidCmd = 1'b0; ConfigDiv = 1'b0;
            end
            chk($sformatf("%s_dout%0d", tag, i), 32'(DataOut), (pkt >> (28 - 4 * i)) & 32'hF);
            chk($sformatf("%s_dvalid%0d", tag, i), 32'(DoutValid), 32'd1);
            chk($sformatf("%s_clktx%0d", tag, i), 32'(ClkTx), (ph >= div) ? 32'd1 : 32'd0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(CalcBusy), 32'd1);
            @(posedge Clk); #1;
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        Reset = 1'b0; InputKey = 1'b0; ValidCmd = 1'b0; RW = 1'b0; ConfigDiv = 1'b0;
        InA = '0; InB = '0; Addr = '0; Sel = '0; Din = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk_idle("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // Default divider of 1 straight out of reset
        run_cmd("div1_xor", 0, 0, 0, 8'hA5, 8'h0F, 5, 0, -1);

        config_div(3);
        run_cmd("add_4_4", 0, 0, 0, 4, 4, 0, 0, -1);
        run_cmd("sub_borrow", 0, 0, 0, 3, 5, 1, 0, -1);
        run_cmd("mul_carry", 0, 0, 0, 16, 16, 2, 0, -1);

        config_div(1);
        run_cmd("mem_wr0", 1, 1, 0, 4, 4, 0, 0, -1);
        run_cmd("mem_rd0", 1, 0, 0, 9, 9, 5, 0, -1);
        run_cmd("mem_rd1", 1, 0, 1, 7, 2, 7, 0, -1);
        run_cmd("invalid", 0, 0, 0, 200, 100, 12, 0, -1);

        config_div(2);
        run_cmd("disturb", 0, 0, 0, 0, 0, 6, 1, -1);
        run_cmd("after_dist", 0, 0, 0, 255, 1, 0, 0, -1);

        config_div(0);
        run_cmd("div0_shr", 0, 0, 0, 8'h80, 3, 8, 0, -1);

        config_div(3);
        run_cmd("mid_rst", 0, 0, 0, 50, 60, 4, 0, 20);
        run_cmd("post_rst", 0, 0, 0, 50, 60, 3, 0, -1);

        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 2) == 0) config_div(int'($urandom_range(0, 3)));
            run_cmd($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
